// File: rtl/histogram_builder_if.sv
// Pixel stream, bin-array port and dump stream of the histogram controller.
// master is the controller side, slave is the surrounding datapath side.
interface histogram_builder_if;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic        arr_wr_en;
  logic [7:0]  arr_index;
  logic [15:0] arr_wr_val;
  logic [15:0] arr_rd_val;
  logic        dump_valid;
  logic [7:0]  dump_bin;
  logic [15:0] dump_count;

  modport master (
    input  pix_valid, pix_data, pix_last, arr_rd_val,
    output pix_ready, arr_wr_en, arr_index, arr_wr_val, dump_valid, dump_bin, dump_count
  );
  modport slave (
    output pix_valid, pix_data, pix_last, arr_rd_val,
    input  pix_ready, arr_wr_en, arr_index, arr_wr_val, dump_valid, dump_bin, dump_count
  );
endinterface

// File: rtl/histogram_builder.sv
// Frame histogram controller: clears 256 bins, accumulates pixels by
// read-modify-write into the external bin array, then streams all bins out.
module histogram_builder (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  histogram_builder_if.master        bus,
  output logic                       busy,
  output logic                       done
);
  typedef enum logic [2:0] {IDLE, CLEAR, ACC_RD, ACC_WR, DUMP, DRAIN} state_t;

  state_t      state;
  logic [7:0]  cnt, hold_idx, dump_bin_q;
  logic        hold_last, dump_valid_q, done_q;
  logic        wr_en;
  logic [7:0]  index;
  logic [15:0] wr_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hold_idx     <= '0;
      hold_last    <= 1'b0;
      dump_bin_q   <= '0;
      dump_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CLEAR;
          cnt   <= '0;
        end
        CLEAR: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hFF) state <= ACC_RD;
        end
        ACC_RD: if (bus.pix_valid) begin
          hold_idx  <= bus.pix_data;
          hold_last <= bus.pix_last;
          state     <= ACC_WR;
        end
        ACC_WR: begin
          if (hold_last) begin
            state <= DUMP;
            cnt   <= '0;
          end else begin
            state <= ACC_RD;
          end
        end
        DUMP: begin
          dump_valid_q <= 1'b1;
          dump_bin_q   <= cnt;
          cnt          <= cnt + 8'd1;
          if (cnt == 8'hFF) state <= DRAIN;
        end
        // bin-255 beat is on the bus during this cycle
        DRAIN: begin
          dump_valid_q <= 1'b0;
          done_q       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    index  = '0;
    wr_val = '0;
    case (state)
      CLEAR:  begin wr_en = 1'b1; index = cnt; end
      ACC_RD: index = bus.pix_data;
      // increment saturates so a full bin never wraps back to zero
      ACC_WR: begin
        wr_en  = 1'b1;
        index  = hold_idx;
        wr_val = (bus.arr_rd_val == 16'hFFFF) ? 16'hFFFF : bus.arr_rd_val + 16'd1;
      end
      DUMP:   index = cnt;
      default: ;
    endcase
  end

  assign bus.arr_wr_en  = wr_en;
  assign bus.arr_index  = index;
  assign bus.arr_wr_val = wr_val;
  assign bus.pix_ready  = (state == ACC_RD);
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_bin   = dump_bin_q;
  assign bus.dump_count = bus.arr_rd_val;
  assign busy           = (state != IDLE);
  assign done           = done_q;
endmodule
